// File: rtl/ram_dp_wbe_pipe_pkg.sv
// Shared definitions for the dual-port byte-enable RAM: latency encodings and
// the byte-lane merge used by writes, write-first reads and collision merging.
package ram_dp_wbe_pipe_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int NUM_BYTES  = DEF_DWIDTH / 8;

  localparam int LAT_ASYNC = 0;
  localparam int LAT_REG   = 1;
  localparam int LAT_REG2  = 2;

  // The merge works on the widest supported word; callers zero-extend and truncate.
  localparam int MAX_DWIDTH = 512;
  localparam int MAX_BYTES  = MAX_DWIDTH / 8;

  typedef logic [MAX_DWIDTH-1:0] word_t;
  typedef logic [MAX_BYTES-1:0]  wbe_t;

  function automatic int num_bytes(input int dwidth);
    return dwidth / 8;
  endfunction

  function automatic word_t merge(input word_t old_w, input word_t new_w, input wbe_t wbe);
    word_t res;
    res = old_w;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (wbe[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return pipeline for one RAM port: 0, 1 or 2 register stages carrying
// data, valid and error, with synchronous active-low reset.
module ram_rd_pipe
  import ram_dp_wbe_pipe_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int LAT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic              rd_err,
  input  logic [DWIDTH-1:0] rd_data,
  output logic [DWIDTH-1:0] q,
  output logic              q_valid,
  output logic              err
);

  if (LAT == LAT_ASYNC) begin : g_async
    logic unused_clk;
    assign unused_clk = clk;
    assign q          = rd_data;
    assign q_valid    = rst_n & rd_req;
    assign err        = rst_n & rd_err;
  end else begin : g_reg
    logic [DWIDTH-1:0] data_s  [LAT];
    logic              valid_s [LAT];
    logic              err_s   [LAT];

    // Data stages only advance behind a valid, so q holds between reads.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < LAT; i++) begin
          data_s[i]  <= '0;
          valid_s[i] <= 1'b0;
          err_s[i]   <= 1'b0;
        end
      end else begin
        valid_s[0] <= rd_req;
        err_s[0]   <= rd_req & rd_err;
        if (rd_req) data_s[0] <= rd_data;
        for (int i = 1; i < LAT; i++) begin
          valid_s[i] <= valid_s[i-1];
          err_s[i]   <= err_s[i-1];
          if (valid_s[i-1]) data_s[i] <= data_s[i-1];
        end
      end
    end

    assign q       = data_s[LAT-1];
    assign q_valid = valid_s[LAT-1];
    assign err     = err_s[LAT-1];
  end

endmodule

// File: rtl/ram_dp_wbe_pipe.sv
// Dual-port byte-enable RAM with selectable read latency, collision merging
// and out-of-range error reporting. Port 0 is fetch, port 1 is load/store.
module ram_dp_wbe_pipe
  import ram_dp_wbe_pipe_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 12,
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 0,
  parameter int WRITE_FIRST  = 1,
  parameter     MIF_HEX      = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en0,
  input  logic                wen0,
  input  logic [DWIDTH/8-1:0] wbe0,
  input  logic [AWIDTH-1:0]   addr0,
  input  logic [DWIDTH-1:0]   d0,
  output logic [DWIDTH-1:0]   q0,
  output logic                q0_valid,
  output logic                err0,
  input  logic                en1,
  input  logic                wen1,
  input  logic [DWIDTH/8-1:0] wbe1,
  input  logic [AWIDTH-1:0]   addr1,
  input  logic [DWIDTH-1:0]   d1,
  output logic [DWIDTH-1:0]   q1,
  output logic                q1_valid,
  output logic                err1
);

  localparam int NUM_BYTES_W = num_bytes(DWIDTH);
  localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The implementation flow preloads the array from MIF_HEX; the RTL never reads it.
  localparam unused_mif = MIF_HEX;

  function automatic logic [DWIDTH-1:0] merge_w(input logic [DWIDTH-1:0] old_w,
                                                input logic [DWIDTH-1:0] new_w,
                                                input logic [NUM_BYTES_W-1:0] be);
    word_t r;
    r = merge(word_t'(old_w), word_t'(new_w), wbe_t'(be));
    return r[DWIDTH-1:0];
  endfunction

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              in0, in1;
  logic [IDX_W-1:0]  idx0, idx1;
  logic [DWIDTH-1:0] mem_rd0, mem_rd1;
  logic [DWIDTH-1:0] own0, own1, wr1;
  logic              we0, we1, collide;

  assign in0     = (32'(addr0) < DEPTH);
  assign in1     = (32'(addr1) < DEPTH);
  assign idx0    = addr0[IDX_W-1:0];
  assign idx1    = addr1[IDX_W-1:0];
  assign mem_rd0 = mem[idx0];
  assign mem_rd1 = mem[idx1];

  // Requests are single-cycle strobes (en, qualified wen); there is no backpressure.
  assign we0     = rst_n & en0 & wen0 & in0 & (|wbe0);
  assign we1     = rst_n & en1 & wen1 & in1 & (|wbe1);
  assign collide = we0 & we1 & (idx0 == idx1);

  assign own0 = merge_w(mem_rd0, d0, wbe0);
  assign own1 = merge_w(mem_rd1, d1, wbe1);
  // On a same-word collision port 1 lands on top of port 0's merged word.
  assign wr1  = collide ? merge_w(own0, d1, wbe1) : own1;

  always_ff @(posedge clk) begin
    if (we0 && !collide) mem[idx0] <= own0;
    if (we1)             mem[idx1] <= wr1;
  end

  // Reads see only the array plus the port's own write, never the other port's.
  logic [DWIDTH-1:0] old0, old1, cap0, cap1, rdd0, rdd1;
  logic              req0, req1;

  assign old0 = in0 ? mem_rd0 : '0;
  assign old1 = in1 ? mem_rd1 : '0;
  assign cap0 = (in0 && wen0 && WRITE_FIRST != 0) ? own0 : old0;
  assign cap1 = (in1 && wen1 && WRITE_FIRST != 0) ? own1 : old1;
  assign rdd0 = (READ_LATENCY == LAT_ASYNC) ? old0 : cap0;
  assign rdd1 = (READ_LATENCY == LAT_ASYNC) ? old1 : cap1;
  assign req0 = (READ_LATENCY == LAT_ASYNC) ? (en0 & ~wen0) : en0;
  assign req1 = (READ_LATENCY == LAT_ASYNC) ? (en1 & ~wen1) : en1;

  ram_rd_pipe #(.DWIDTH(DWIDTH), .LAT(READ_LATENCY)) u_rd_pipe0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_req  (req0),
    .rd_err  (en0 & ~in0),
    .rd_data (rdd0),
    .q       (q0),
    .q_valid (q0_valid),
    .err     (err0)
  );

  ram_rd_pipe #(.DWIDTH(DWIDTH), .LAT(READ_LATENCY)) u_rd_pipe1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_req  (req1),
    .rd_err  (en1 & ~in1),
    .rd_data (rdd1),
    .q       (q1),
    .q_valid (q1_valid),
    .err     (err1)
  );

endmodule

// File: tb/tb_ram_dp_wbe_pipe.sv
// Directed bench for ram_dp_wbe_pipe: four instances (LAT0, LAT1 write-first,
// LAT1 read-first, LAT2) each driven by its own input set.
module tb_ram_dp_wbe_pipe;

  typedef struct {
    logic        en;
    logic        wen;
    logic [3:0]  wbe;
    logic [11:0] addr;
    logic [31:0] d;
  } port_in_t;

  logic        clk;
  logic        rst_n;
  port_in_t    pi0 [4];
  port_in_t    pi1 [4];
  logic [31:0] q0_o [4];
  logic [31:0] q1_o [4];
  logic        q0_v [4];
  logic        q1_v [4];
  logic        e0_o [4];
  logic        e1_o [4];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ram_dp_wbe_pipe #(
      .DWIDTH       (32),
      .AWIDTH       (12),
      .DEPTH        (1024),
      .READ_LATENCY ((g == 0) ? 0 : ((g == 3) ? 2 : 1)),
      .WRITE_FIRST  ((g == 2) ? 0 : 1),
      .MIF_HEX      ("")
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en0      (pi0[g].en),
      .wen0     (pi0[g].wen),
      .wbe0     (pi0[g].wbe),
      .addr0    (pi0[g].addr),
      .d0       (pi0[g].d),
      .q0       (q0_o[g]),
      .q0_valid (q0_v[g]),
      .err0     (e0_o[g]),
      .en1      (pi1[g].en),
      .wen1     (pi1[g].wen),
      .wbe1     (pi1[g].wbe),
      .addr1    (pi1[g].addr),
      .d1       (pi1[g].d),
      .q1       (q1_o[g]),
      .q1_valid (q1_v[g]),
      .err1     (e1_o[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set0(input int g, input logic en, input logic wen, input logic [3:0] wbe,
                      input logic [11:0] addr, input logic [31:0] d);
    pi0[g].en = en; pi0[g].wen = wen; pi0[g].wbe = wbe; pi0[g].addr = addr; pi0[g].d = d;
  endtask

  task automatic set1(input int g, input logic en, input logic wen, input logic [3:0] wbe,
                      input logic [11:0] addr, input logic [31:0] d);
    pi1[g].en = en; pi1[g].wen = wen; pi1[g].wbe = wbe; pi1[g].addr = addr; pi1[g].d = d;
  endtask

  task automatic idle_all();
    for (int g = 0; g < 4; g++) begin
      set0(g, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
      set1(g, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
    end
  endtask

  // checkers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  logic [11:0] s_addr [4];
  logic [31:0] s_word [4];

  initial begin
    s_addr = '{12'd5, 12'd10, 12'd20, 12'd30};
    s_word = '{32'hC0DE0005, 32'hC0DE0010, 32'hC0DE0020, 32'hC0DE0030};

    rst_n = 1'b0;
    idle_all();
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk_b($sformatf("rst_v0_%0d", g), q0_v[g], 1'b0);
      chk_b($sformatf("rst_v1_%0d", g), q1_v[g], 1'b0);
      chk_b($sformatf("rst_e0_%0d", g), e0_o[g], 1'b0);
      chk_b($sformatf("rst_e1_%0d", g), e1_o[g], 1'b0);
      if (g != 0) begin
        chk($sformatf("rst_q0_%0d", g), q0_o[g], 32'h0);
        chk($sformatf("rst_q1_%0d", g), q1_o[g], 32'h0);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);

    // latency 0: cross-port write then combinational read
    set1(0, 1'b1, 1'b1, 4'hF, 12'd40, 32'hDEADBEEF);
    @(negedge clk);
    set1(0, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
    set0(0, 1'b1, 1'b0, 4'h0, 12'd40, 32'h0);
    #1;
    chk("l0_q0", q0_o[0], 32'hDEADBEEF);
    chk_b("l0_v0", q0_v[0], 1'b1);
    chk_b("l0_e0", e0_o[0], 1'b0);
    @(negedge clk);
    set0(0, 1'b1, 1'b1, 4'h0, 12'd40, 32'h12345678);
    #1;
    chk_b("l0_wr_v0", q0_v[0], 1'b0);
    @(negedge clk);
    set0(0, 1'b1, 1'b0, 4'h0, 12'd40, 32'h0);
    #1;
    chk("l0_wbe0_q0", q0_o[0], 32'hDEADBEEF);
    @(negedge clk);
    set0(0, 1'b1, 1'b0, 4'h0, 12'd1024, 32'h0);
    #1;
    chk("l0_oor_q0", q0_o[0], 32'h0);
    chk_b("l0_oor_v0", q0_v[0], 1'b1);
    chk_b("l0_oor_e0", e0_o[0], 1'b1);
    @(negedge clk);
    set0(0, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
    #1;
    chk_b("l0_idle_e0", e0_o[0], 1'b0);

    // latency 1: same-port read/write, write-first vs read-first
    for (int g = 1; g <= 2; g++) set0(g, 1'b1, 1'b1, 4'hF, 12'd20, 32'h11223344);
    @(negedge clk);
    for (int g = 1; g <= 2; g++) begin
      set0(g, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
      set1(g, 1'b1, 1'b1, 4'h7, 12'd20, 32'hFFFFFFFF);
    end
    @(negedge clk);
    chk("wf1_q1", q1_o[1], 32'h11FFFFFF);
    chk_b("wf1_v1", q1_v[1], 1'b1);
    chk_b("wf1_e1", e1_o[1], 1'b0);
    chk("wf0_q1", q1_o[2], 32'h11223344);
    chk_b("wf0_v1", q1_v[2], 1'b1);
    for (int g = 1; g <= 2; g++) begin
      set1(g, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
      set0(g, 1'b1, 1'b0, 4'h0, 12'd20, 32'h0);
    end
    @(negedge clk);
    chk("wf1_mem20", q0_o[1], 32'h11FFFFFF);
    chk("wf0_mem20", q0_o[2], 32'h11FFFFFF);
    chk_b("wf1_v1_idle", q1_v[1], 1'b0);
    chk("wf1_q1_hold", q1_o[1], 32'h11FFFFFF);
    chk("wf0_q1_hold", q1_o[2], 32'h11223344);
    for (int g = 1; g <= 2; g++) begin
      set0(g, 1'b1, 1'b1, 4'hF, 12'd20, 32'hA5A5A5A5);
      set1(g, 1'b1, 1'b0, 4'h0, 12'd20, 32'h0);
    end
    @(negedge clk);
    chk("xrd_old_wf1", q1_o[1], 32'h11FFFFFF);
    chk("xrd_old_wf0", q1_o[2], 32'h11FFFFFF);
    for (int g = 1; g <= 2; g++) set0(g, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
    @(negedge clk);
    chk("xrd_new_wf1", q1_o[1], 32'hA5A5A5A5);
    chk("xrd_new_wf0", q1_o[2], 32'hA5A5A5A5);
    for (int g = 1; g <= 2; g++) set1(g, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);

    // dual write merge on instance 1
    set0(1, 1'b1, 1'b1, 4'hF, 12'd7, 32'hAAAAAAAA);
    set1(1, 1'b1, 1'b1, 4'h3, 12'd7, 32'h5555BBBB);
    @(negedge clk);
    chk("dual_q0_own", q0_o[1], 32'hAAAAAAAA);
    set1(1, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
    set0(1, 1'b1, 1'b0, 4'h0, 12'd7, 32'h0);
    @(negedge clk);
    chk("dual_mem7", q0_o[1], 32'hAAAABBBB);
    set0(1, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);

    // out of range on instance 1 (DEPTH 1024)
    set1(1, 1'b1, 1'b1, 4'hF, 12'd0, 32'h0BADF00D);
    @(negedge clk);
    set1(1, 1'b1, 1'b1, 4'hF, 12'd1024, 32'h12345678);
    @(negedge clk);
    chk("oor_wr_q1", q1_o[1], 32'h0);
    chk_b("oor_wr_v1", q1_v[1], 1'b1);
    chk_b("oor_wr_e1", e1_o[1], 1'b1);
    set1(1, 1'b1, 1'b0, 4'h0, 12'd0, 32'h0);
    @(negedge clk);
    chk("oor_no_alias", q1_o[1], 32'h0BADF00D);
    chk_b("oor_e1_clear", e1_o[1], 1'b0);
    set1(1, 1'b1, 1'b0, 4'h0, 12'd1024, 32'h0);
    @(negedge clk);
    chk("oor_rd_q1", q1_o[1], 32'h0);
    chk_b("oor_rd_v1", q1_v[1], 1'b1);
    chk_b("oor_rd_e1", e1_o[1], 1'b1);
    set1(1, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
    @(negedge clk);
    chk_b("oor_idle_e1", e1_o[1], 1'b0);
    chk_b("oor_idle_v1", q1_v[1], 1'b0);

    // latency 2: fill then stream four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      set1(3, 1'b1, 1'b1, 4'hF, s_addr[i], s_word[i]);
      @(negedge clk);
    end
    set1(3, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
    @(negedge clk);
    for (int j = 0; j < 7; j++) begin
      chk_b($sformatf("l2_v0_%0d", j), q0_v[3], (j >= 2 && j <= 5));
      if (j >= 2) chk($sformatf("l2_q0_%0d", j), q0_o[3], s_word[(j - 2 > 3) ? 3 : j - 2]);
      if (j < 4) set0(3, 1'b1, 1'b0, 4'h0, s_addr[j], 32'h0);
      else       set0(3, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
      @(negedge clk);
    end

    // latency 2: reset discards in-flight and in-reset requests and blocks writes
    set0(3, 1'b1, 1'b0, 4'h0, 12'd5, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    set0(3, 1'b1, 1'b0, 4'h0, 12'd20, 32'h0);
    set1(3, 1'b1, 1'b1, 4'hF, 12'd30, 32'h0);
    @(negedge clk);
    chk("rs_q0", q0_o[3], 32'h0);
    chk_b("rs_v0", q0_v[3], 1'b0);
    rst_n = 1'b1;
    set1(3, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
    set0(3, 1'b1, 1'b0, 4'h0, 12'd10, 32'h0);
    @(negedge clk);
    chk_b("rs_inreset_v0", q0_v[3], 1'b0);
    set0(3, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
    @(negedge clk);
    chk_b("rs_post_v0", q0_v[3], 1'b1);
    chk("rs_post_q0", q0_o[3], 32'hC0DE0010);
    set0(3, 1'b1, 1'b0, 4'h0, 12'd30, 32'h0);
    @(negedge clk);
    chk_b("rs_gap_v0", q0_v[3], 1'b0);
    set0(3, 1'b0, 1'b0, 4'h0, 12'd0, 32'h0);
    @(negedge clk);
    chk("rs_wr_blocked", q0_o[3], 32'hC0DE0030);
    chk_b("rs_wr_blocked_v0", q0_v[3], 1'b1);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_dp_wbe_pipe.md
Name: ram_dp_wbe_pipe

Overview:
- Parametrised successor to the async-read/sync-write dual-port byte-enable RAM. It adds selectable read latency (0/1/2), a read-valid pipeline, a defined same-address collision policy, cross-port write merging and a DEPTH bound with error reporting.
- Port 0 serves instruction fetch; port 1 serves data load/store. Both ports have full read/write capability.

Parameters:
- DWIDTH, 32, data width; must be a multiple of 8.
- AWIDTH, 12, word-address width.
- DEPTH, 4096, number of implemented words; must be ≤ 2^AWIDTH.
- READ_LATENCY, 0, cycles from request to q: 0 = combinational, 1 = one output register, 2 = two output registers.
- WRITE_FIRST, 1, same-port same-cycle read/write: 1 returns new data, 0 returns old data. Ignored when READ_LATENCY = 0.
- MIF_HEX, "", memory init file; empty means no init.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- en0  in  1  port-0 request strobe.
- wen0  in  1  port-0 write enable; qualified by en0.
- wbe0  in  DWIDTH/8  port-0 byte enables.
- addr0  in  AWIDTH  port-0 word address.
- d0  in  DWIDTH  port-0 write data.
- q0  out  DWIDTH  port-0 read data.
- q0_valid  out  1  port-0 read data valid.
- err0  out  1  port-0 out-of-range access flag.
- en1, wen1, wbe1, addr1, d1, q1, q1_valid, err1: same as port 0, for port 1.

Behaviour:
- Write: on posedge with en=1, wen=1, addr<DEPTH, byte i of mem[addr] takes d[8i+7:8i] for every wbe[i]=1. wbe=0 means no write.
- Reset:
  - rst_n is sampled on posedge; it clears pipeline registers, q0/q1 to 0, q*_valid and err* to 0.
  - Memory contents are not cleared.
  - Writes presented in the reset cycle are blocked.
  - In-flight reads are discarded: valid stays 0 for requests issued before or during reset.
- Read, READ_LATENCY=0:
  - q = mem[addr] combinationally, regardless of en.
  - q_valid = en & ~wen.
  - A write becomes visible the cycle after its posedge.
  - WRITE_FIRST has no effect.
- Read, READ_LATENCY=1:
  - A read request (en=1, wen=0) at cycle N gives q/q_valid=1 in cycle N+1.
  - When no read is issued, q holds its last value and q_valid=0.
- Read, READ_LATENCY=2: same as latency 1 with one extra register stage. The result appears in cycle N+2. Back-to-back requests give one result per cycle with no bubbles.
- Same-port read and write (en=1, wen=1, wbe≠0), latency ≥1:
  - The cycle counts as a read; valid follows at +LAT.
  - WRITE_FIRST=1 returns merged new data.
  - WRITE_FIRST=0 returns pre-write contents.
- Cross-port collision, same addr, both writing: byte-wise merge. Port 1 wins on bytes enabled by both; the rest come from whichever port enabled them.
- Cross-port read of an address written by the other port in the same cycle:
  - Latency ≥1: the read returns old data (read-first across ports).
  - Latency 0: new data appears the next cycle.
- Out of range (en=1 and addr≥DEPTH):
  - The write is suppressed.
  - A read returns 0 with valid asserted at the normal latency.
  - err pulses for one cycle, aligned with when q would be valid (latency 0: combinational).
- Address wrap: none. Addresses ≥DEPTH never alias.
- Reset deasserting mid-pipeline: the first valid appears exactly LAT cycles after the first post-reset request.

Decomposition:
- Shared package: NUM_BYTES = DWIDTH/8, latency encodings (LAT_ASYNC=0, LAT_REG=1, LAT_REG2=2), and the byte-merge function merge(old, new, wbe).
- One sub-module: ram_rd_pipe. It is a parametrised 0/1/2-stage register for q/valid/err with synchronous reset and is instantiated once per port.
- The storage array and write/collision logic stay in the top.

Test Plan:
- LAT=0: write 0xDEADBEEF to addr 40 via port 1 with wbe=1111, then read addr 40 on port 0 the next cycle -> q0=0xDEADBEEF and q0_valid=1 combinationally.
- LAT=1, WRITE_FIRST=1: mem[20]=0x11223344, then port 1 with wbe=0111, d=0xFFFFFFFF, en=wen=1 -> next cycle q1=0x11FFFFFF and q1_valid=1. With WRITE_FIRST=0 -> q1=0x11223344.
- LAT=2 streaming: port 0 reads addr 5, 10, 20, 30 on consecutive cycles -> q0 returns the four words in order in cycles N+2..N+5, q0_valid high for 4 consecutive cycles.
- Dual write to addr 7 with port 0 wbe=1111 d=0xAAAAAAAA and port 1 wbe=0011 d=0x5555BBBB -> mem[7]=0xAAAABBBB.
- DEPTH=1024, LAT=1: port 1 writes addr 1024 -> no memory change, err1=1 one cycle later. A read of addr 1024 -> q1=0, q1_valid=1, err1=1.
- LAT=2: issue a read, assert rst_n=0 for one cycle after it -> q0_valid never rises for that read and q0=0. A read issued after reset deasserts returns valid 2 cycles later.
